// File: rtl/mem_cycle_ctl_pkg.sv
// Shared definitions for the memory cycle controller: op encodings, FSM states
// and data/address widths.
package mem_cycle_ctl_pkg;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 15;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_INCR  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    HOLD        = 3'd0,
    IDLE        = 3'd1,
    START       = 3'd2,
    WAIT_STROBE = 3'd3,
    WAIT_DONE   = 3'd4,
    RELEASE     = 3'd5
  } state_e;

  // The reserved encoding behaves as a plain read (restore the original word).
  function automatic op_e decode_op(input logic [1:0] raw);
    op_e op;
    op = (raw == 2'b11) ? OP_READ : op_e'(raw);
    return op;
  endfunction

endpackage

// File: rtl/mem_cycle_ctl.sv
// Read/modify/write cycle sequencer for a destructive-read memory with a
// post-reset holdoff and a cycle watchdog.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// HOLD        | after reset; wait HOLDOFF clocks so an in-flight cycle drains
// IDLE        | req_ready=1, waiting for a request
// START       | raise mem_start
// WAIT_STROBE | wait for first strobe_n low; mem_done_n may be stale here
// WAIT_DONE   | write-back word loaded; wait for mem_done_n low
// RELEASE     | one clock with mem_start low before returning to IDLE
module mem_cycle_ctl
  import mem_cycle_ctl_pkg::*;
#(
  parameter int WDOG_LIMIT = 255,
  parameter int HOLDOFF    = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              mem_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              strobe_n,
  input  logic              mem_done_n
);

  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  op_e                 op_q, op_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_start_q, mem_start_d;
  logic                wb_pend_q, wb_pend_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_zero_q, rsp_zero_d;

  logic [WDOG_W-1:0]   wdog_inc;
  logic                wdog_hit;
  logic [DATA_W-1:0]   inc_data;

  assign wdog_inc = wdog_q + 1'b1;
  assign wdog_hit = (wdog_inc == WDOG_W'(WDOG_LIMIT));
  assign inc_data = rdata_q + DATA_W'(1);

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    wdog_d      = '0;
    op_d        = op_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;
    mem_start_d = mem_start_q;
    wb_pend_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_zero_d  = 1'b0;

    // Write-back word is formed the clock after the strobe latched the read.
    if (wb_pend_q) begin
      case (op_q)
        OP_WRITE: mem_wdata_d = wdata_q;
        OP_INCR:  mem_wdata_d = inc_data;
        default:  mem_wdata_d = rdata_q;
      endcase
    end

    case (state_q)
      HOLD: begin
        if (hold_cnt_q == '0) state_d = IDLE;
        else                  hold_cnt_d = hold_cnt_q - 1'b1;
      end

      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          op_d    = decode_op(req_op);
          wdata_d = req_wdata;
          state_d = START;
        end
      end

      START: begin
        wdog_d = wdog_inc;
        if (wdog_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          mem_start_d = 1'b0;
          state_d     = RELEASE;
        end else begin
          mem_start_d = 1'b1;
          state_d     = WAIT_STROBE;
        end
      end

      WAIT_STROBE: begin
        wdog_d = wdog_inc;
        if (wdog_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          mem_start_d = 1'b0;
          state_d     = RELEASE;
        end else if (!strobe_n) begin
          rdata_d   = mem_data;
          wb_pend_d = 1'b1;
          state_d   = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        wdog_d = wdog_inc;
        if (!mem_done_n) begin
          rsp_valid_d = 1'b1;
          rsp_zero_d  = (op_q == OP_INCR) && (inc_data == '0);
          mem_start_d = 1'b0;
          state_d     = RELEASE;
        end else if (wdog_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          mem_start_d = 1'b0;
          state_d     = RELEASE;
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = HOLD;
        mem_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HOLD;
      hold_cnt_q  <= HOLD_W'(HOLDOFF - 1);
      wdog_q      <= '0;
      op_q        <= OP_READ;
      wdata_q     <= '0;
      addr_q      <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      mem_start_q <= 1'b0;
      wb_pend_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      wdog_q      <= wdog_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
      mem_start_q <= mem_start_d;
      wb_pend_q   <= wb_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign mem_start = mem_start_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
